// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit with one outstanding memory read and a 2-entry buffer
module instr_fetch (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] i_PC,
  output logic        o_incPC,
  input  logic        i_flush,
  output logic        o_memReq,
  output logic [11:0] o_memAddr,
  input  logic        i_memAck,
  input  logic        i_memValid,
  input  logic [15:0] i_memData,
  output logic [15:0] o_instr,
  output logic [11:0] o_instrPC,
  output logic        o_instrValid,
  input  logic        i_instrReady
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t      state_q, state_d;
  logic [1:0]  count_q, count_d, occ;
  logic        discard_q, discard_d;
  logic        start_q;
  logic [11:0] pend_q, pend_d;
  logic [27:0] e0_q, e0_d, e1_q, e1_d;
  logic        push, pop;
  // FIFO bookkeeping: a flush empties the buffer and masks any pop in the same cycle
  always_comb begin
    push    = (state_q == WAIT) && i_memValid && !discard_q && !i_flush;
    pop     = (count_q != 2'd0) && i_instrReady && !i_flush;
    occ     = count_q - {1'b0, pop};
    count_d = i_flush ? 2'd0 : occ + {1'b0, push};
    e0_d    = pop ? e1_q : e0_q;
    e1_d    = e1_q;
    if (push && occ == 2'd0) e0_d = {pend_q, i_memData};
    if (push && occ != 2'd0) e1_d = {pend_q, i_memData};
  end
  // Fetch FSM: credit check keeps buffered plus in-flight entries within the 2-entry FIFO
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    pend_d    = pend_q;
    o_incPC   = 1'b0;
    o_memReq  = 1'b0;
    case (state_q)
      IDLE: state_d = (!i_flush && start_q && count_q < 2'd2) ? REQ : IDLE;
      REQ: begin
        o_memReq = !i_flush;
        if (i_flush) state_d = IDLE;
        else if (i_memAck) begin
          o_incPC = 1'b1;
          pend_d  = i_PC;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_memValid) begin
          discard_d = 1'b0;
          state_d   = (!i_flush && count_d < 2'd2) ? REQ : IDLE;
        end else if (i_flush) discard_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are forced to zero when no request or no entry is present, so reset clears them at once
  assign o_memAddr    = (state_q == REQ) ? i_PC : 12'd0;
  assign o_instrValid = count_q != 2'd0;
  assign o_instr      = o_instrValid ? e0_q[15:0] : 16'd0;
  assign o_instrPC    = o_instrValid ? e0_q[27:16] : 12'd0;
  // State registers; start_q delays the first request to the second edge after reset release
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      count_q   <= 2'd0;
      discard_q <= 1'b0;
      start_q   <= 1'b0;
      pend_q    <= 12'd0;
      e0_q      <= 28'd0;
      e1_q      <= 28'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      discard_q <= discard_d;
      start_q   <= 1'b1;
      pend_q    <= pend_d;
      e0_q      <= e0_d;
      e1_q      <= e1_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios with a PC/memory driver and a scoreboard monitor
module tb_instr_fetch;
  logic        clk = 0;
  logic        i_rst = 1;
  logic [11:0] i_PC = 0;
  logic        o_incPC;
  logic        i_flush = 0;
  logic        o_memReq;
  logic [11:0] o_memAddr;
  logic        i_memAck = 0;
  logic        i_memValid = 0;
  logic [15:0] i_memData = 0;
  logic [15:0] o_instr;
  logic [11:0] o_instrPC;
  logic        o_instrValid;
  logic        i_instrReady = 0;

  instr_fetch dut (
    .i_clk(clk), .i_rst(i_rst), .i_PC(i_PC), .o_incPC(o_incPC), .i_flush(i_flush),
    .o_memReq(o_memReq), .o_memAddr(o_memAddr), .i_memAck(i_memAck),
    .i_memValid(i_memValid), .i_memData(i_memData), .o_instr(o_instr),
    .o_instrPC(o_instrPC), .o_instrValid(o_instrValid), .i_instrReady(i_instrReady)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  logic [27:0] exp_q[$];

  int          ack_left = 0;
  int          resp_dly = 0;
  int          dly = 0;
  int          inc_count = 0;
  logic        have_pend = 0;
  logic [11:0] pend_addr = 0;
  logic        rdy = 1;
  logic        flush_req = 0;
  logic        flush_on_valid = 0;
  logic [11:0] flush_pc = 0;
  logic        last_inc = 0;
  logic        last_flush = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // PC register and memory model, all inputs driven from negedge
  initial begin
    forever begin
      @(negedge clk);
      if (last_flush) i_PC = flush_pc;
      else if (last_inc) i_PC = i_PC + 12'd1;
      i_flush = flush_req;
      flush_req = 0;
      i_instrReady = rdy;
      i_memValid = 0;
      if (have_pend) begin
        if (dly == 0) begin
          i_memValid = 1;
          i_memData = 16'h1000 + {4'h0, pend_addr};
          have_pend = 0;
          if (flush_on_valid) begin
            i_flush = 1;
            flush_on_valid = 0;
          end
        end else dly--;
      end
      #1;
      i_memAck = o_memReq && ack_left > 0;
      if (i_memAck) begin
        have_pend = 1;
        pend_addr = o_memAddr;
        dly = resp_dly;
        ack_left--;
      end
      #1;
      last_inc = o_incPC;
      last_flush = i_flush;
      if (o_incPC) inc_count++;
    end
  end

  // Scoreboard monitor: compares every consumed head entry against the expected queue
  initial begin
    logic [27:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (!i_rst && o_instrValid && i_instrReady && !i_flush) begin
        if (exp_q.size() == 0) chk("unexpected_instr", {4'h0, o_instrPC, o_instr}, 32'hFFFFFFFF);
        else begin
          e = exp_q.pop_front();
          chk("instr", o_instr, e[15:0]);
          chk("instrPC", o_instrPC, e[27:16]);
        end
      end
      if (dut.count_q > 2'd2) chk("fifo_overflow", dut.count_q, 2);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic [11:0] pc);
    @(posedge clk); #2;
    i_rst = 1; i_PC = pc; have_pend = 0; ack_left = 0; flush_req = 0;
    flush_on_valid = 0; last_inc = 0; last_flush = 0;
    repeat (2) @(posedge clk);
    #2 i_rst = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    #1 chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_inc(input string name, input int target);
    for (int i = 0; i < 40 && inc_count < target; i++) begin
      @(posedge clk); #1;
    end
    chk(name, inc_count, target);
  endtask

  task automatic wait_resp(input string name);
    for (int i = 0; i < 40 && have_pend; i++) begin
      @(posedge clk); #1;
    end
    chk(name, have_pend, 0);
  endtask

  initial begin
    int base, hi;
    // reset state and first request timing
    #12;
    chk("rst_memReq", o_memReq, 0);
    chk("rst_incPC", o_incPC, 0);
    chk("rst_instrValid", o_instrValid, 0);
    chk("rst_memAddr", o_memAddr, 0);
    chk("rst_instr", o_instr, 0);
    chk("rst_instrPC", o_instrPC, 0);
    @(posedge clk); #2 i_rst = 0;
    @(posedge clk); #1 chk("edge1_memReq", o_memReq, 0);
    @(posedge clk); #1 chk("edge2_memReq", o_memReq, 1);
    chk("edge2_memAddr", o_memAddr, 12'h000);

    // straight-line
    base = inc_count;
    exp_q.push_back({12'h000, 16'h1000});
    exp_q.push_back({12'h001, 16'h1001});
    exp_q.push_back({12'h002, 16'h1002});
    ack_left = 3;
    wait_empty("straight_drain");
    repeat (3) @(posedge clk);
    #1 chk("straight_inc", inc_count - base, 3);
    chk("straight_next_addr", o_memAddr, 12'h003);

    // back-pressure
    do_reset(12'h000);
    base = inc_count;
    rdy = 0;
    exp_q.push_back({12'h000, 16'h1000});
    exp_q.push_back({12'h001, 16'h1001});
    exp_q.push_back({12'h002, 16'h1002});
    ack_left = 3;
    wait_inc("bp_two_fetches", base + 2);
    hi = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (o_memReq) hi++;
    end
    chk("bp_memReq_cycles", hi, 0);
    chk("bp_inc", inc_count - base, 2);
    chk("bp_valid", o_instrValid, 1);
    chk("bp_head_pc", o_instrPC, 12'h000);
    chk("bp_head_instr", o_instr, 16'h1000);
    chk("bp_buffered", dut.count_q, 2);
    rdy = 1;
    wait_empty("bp_drain");
    chk("bp_inc_after", inc_count - base, 3);

    // ack stall
    do_reset(12'h010);
    base = inc_count;
    for (int c = 0; c < 5; c++) begin
      chk("stall_memReq", o_memReq, 1);
      chk("stall_memAddr", o_memAddr, 12'h010);
      chk("stall_inc", inc_count - base, 0);
      @(posedge clk); #1;
    end
    exp_q.push_back({12'h010, 16'h1010});
    ack_left = 1;
    wait_empty("stall_drain");
    chk("stall_inc_after", inc_count - base, 1);

    // flush in WAIT
    do_reset(12'h005);
    base = inc_count;
    resp_dly = 3;
    ack_left = 1;
    wait_inc("fw_fetch", base + 1);
    flush_pc = 12'h200;
    flush_req = 1;
    wait_resp("fw_late_data");
    chk("fw_empty", o_instrValid, 0);
    chk("fw_memReq", o_memReq, 1);
    chk("fw_memAddr", o_memAddr, 12'h200);
    resp_dly = 0;
    exp_q.push_back({12'h200, 16'h1200});
    ack_left = 1;
    wait_empty("fw_drain");

    // flush and memValid in the same cycle
    do_reset(12'h020);
    base = inc_count;
    resp_dly = 2;
    flush_pc = 12'h300;
    flush_on_valid = 1;
    ack_left = 1;
    wait_inc("fv_fetch", base + 1);
    wait_resp("fv_data");
    chk("fv_no_push", o_instrValid, 0);
    chk("fv_idle", o_memReq, 0);
    @(posedge clk); #1;
    chk("fv_memReq", o_memReq, 1);
    chk("fv_memAddr", o_memAddr, 12'h300);
    resp_dly = 0;
    exp_q.push_back({12'h300, 16'h1300});
    ack_left = 1;
    wait_empty("fv_drain");

    // address wrap, then async reset mid-WAIT
    do_reset(12'hFFF);
    base = inc_count;
    exp_q.push_back({12'hFFF, 16'h1FFF});
    exp_q.push_back({12'h000, 16'h1000});
    ack_left = 2;
    wait_empty("wrap_drain");
    rdy = 0;
    ack_left = 1;
    wait_inc("wrap_third", base + 3);
    wait_resp("wrap_third_data");
    @(posedge clk); #1;
    chk("wrap_hold_valid", o_instrValid, 1);
    chk("wrap_hold_pc", o_instrPC, 12'h001);
    chk("wrap_hold_instr", o_instr, 16'h1001);
    resp_dly = 6;
    ack_left = 1;
    wait_inc("wrap_fourth", base + 4);
    @(posedge clk); #2 i_rst = 1;
    #1;
    chk("arst_memReq", o_memReq, 0);
    chk("arst_incPC", o_incPC, 0);
    chk("arst_instrValid", o_instrValid, 0);
    chk("arst_memAddr", o_memAddr, 0);
    chk("arst_instr", o_instr, 0);
    chk("arst_instrPC", o_instrPC, 0);
    @(posedge clk); #2 i_rst = 0;
    rdy = 1;
    hi = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (o_instrValid) hi++;
    end
    chk("arst_late_ignored", hi, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
